// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared constants and helpers for the memory responder and its timer:
//   peripheral register offsets, IRQ bit positions, window size and a
//   byte-strobe merge helper.
package mem_responder_pkg;

  // Byte offsets of the peripheral registers inside the 32-byte window
  localparam logic [4:0] MTIME_LO_OFF    = 5'h00;
  localparam logic [4:0] MTIME_HI_OFF    = 5'h04;
  localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
  localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
  localparam logic [4:0] SWIRQ_OFF       = 5'h10;
  localparam logic [4:0] EXTIRQ_OFF      = 5'h14;

  localparam logic [31:0] PERIPH_WINDOW_BYTES = 32'd32;

  // Bit positions inside the IRQ vector handed to the core
  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  // Replace the byte lanes of old_w selected by strb with those of new_w
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_responder_mtimer.sv
// mem_responder_mtimer
//   Machine timer: prescaler, 64-bit mtime and mtimecmp with byte-strobe
//   CPU writes, and the timer-interrupt compare.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   wr_en            CPU write hits the peripheral window this cycle
//   wr_off           byte offset of the written word inside the window
//   wr_strb/wr_data  byte strobes and data of the write
//   mtime, mtimecmp  current register values
//   mti              mtime >= mtimecmp (unsigned)
module mem_responder_mtimer
  import mem_responder_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [4:0]  wr_off,
  input  logic [3:0]  wr_strb,
  input  logic [31:0] wr_data,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mti
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          tick;
  logic [63:0]   mtime_inc;

  always_comb begin
    tick       = (presc_q == PW'(PRESCALE - 1));
    presc_d    = tick ? '0 : presc_q + PW'(1);
    mtime_inc  = tick ? mtime_q + 64'd1 : mtime_q;
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    // Written bytes override the incremented value; the other half keeps
    // whatever the normal increment produced.
    if (wr_en) begin
      case (wr_off)
        MTIME_LO_OFF:    mtime_d[31:0]     = merge_bytes(mtime_inc[31:0], wr_data, wr_strb);
        MTIME_HI_OFF:    mtime_d[63:32]    = merge_bytes(mtime_inc[63:32], wr_data, wr_strb);
        MTIMECMP_LO_OFF: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wr_data, wr_strb);
        MTIMECMP_HI_OFF: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wr_data, wr_strb);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign mtime    = mtime_q;
  assign mtimecmp = mtimecmp_q;
  assign mti      = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder: word-addressed RAM with a registered fetch port,
//   a registered data-read port and a byte-lane write port, plus a 32-byte
//   timer/interrupt peripheral window. Produces the core IRQ vector.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   i_address / instruction    fetch address, registered fetched word
//   read, read_address         data read request
//   read_data                  registered read result (holds when read=0)
//   write_address/_data/write  byte-lane write (write = per-lane strobes)
//   ext_irq                    level external interrupt sources
//   IRQ                        registered interrupt vector
//   access_fault               sticky out-of-range access flag
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          MEM_WORDS   = 16384,
  parameter logic [31:0] PERIPH_BASE = 32'h2000_0000,
  parameter int          PRESCALE    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  output logic [31:0] instruction,
  input  logic        read,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write,
  input  logic [3:0]  ext_irq,
  output logic [31:0] IRQ,
  output logic        access_fault
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] RAM_BYTES = MEM_WORDS * 4;

  function automatic logic in_ram(input logic [31:0] a);
    return a < RAM_BYTES;
  endfunction

  function automatic logic in_periph(input logic [31:0] a);
    return (a >= PERIPH_BASE) && (a < PERIPH_BASE + PERIPH_WINDOW_BYTES);
  endfunction

  logic [31:0] mem [MEM_WORDS];

  logic [31:0] instruction_q, instruction_d;
  logic [31:0] read_data_q, read_data_d;
  logic [31:0] irq_q, irq_d;
  logic        fault_q, fault_d;
  logic        swirq_q, swirq_d;

  logic [63:0] mtime, mtimecmp;
  logic        mti;
  logic        per_we;
  logic [4:0]  wr_off, rd_off;
  logic [3:0]  ram_we;
  logic [31:0] periph_rd;

  assign wr_off = {write_address[4:2], 2'b00};
  assign rd_off = {read_address[4:2], 2'b00};
  assign per_we = (|write) && in_periph(write_address);
  // A write presented while reset is low must not land in the array
  assign ram_we = write & {4{in_ram(write_address) & reset}};

  mem_responder_mtimer #(
    .PRESCALE (PRESCALE)
  ) u_mtimer (
    .clk      (clk),
    .rst_n    (reset),
    .wr_en    (per_we),
    .wr_off   (wr_off),
    .wr_strb  (write),
    .wr_data  (write_data),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .mti      (mti)
  );

  always_comb begin
    periph_rd = '0;
    case (rd_off)
      MTIME_LO_OFF:    periph_rd = mtime[31:0];
      MTIME_HI_OFF:    periph_rd = mtime[63:32];
      MTIMECMP_LO_OFF: periph_rd = mtimecmp[31:0];
      MTIMECMP_HI_OFF: periph_rd = mtimecmp[63:32];
      SWIRQ_OFF:       periph_rd = {31'd0, swirq_q};
      EXTIRQ_OFF:      periph_rd = {28'd0, ext_irq};
      default:         periph_rd = '0;
    endcase
  end

  always_comb begin
    // Array is read combinationally before this edge's write, giving
    // read-first behaviour on both ports.
    instruction_d = in_ram(i_address) ? mem[i_address[AW+1:2]] : '0;

    read_data_d = read_data_q;
    if (read) begin
      if (in_ram(read_address))         read_data_d = mem[read_address[AW+1:2]];
      else if (in_periph(read_address)) read_data_d = periph_rd;
      else                              read_data_d = '0;
    end

    swirq_d = swirq_q;
    if (per_we && (wr_off == SWIRQ_OFF) && write[0]) swirq_d = write_data[0];

    irq_d          = '0;
    irq_d[IRQ_MSI] = swirq_q;
    irq_d[IRQ_MTI] = mti;
    irq_d[IRQ_MEI] = |ext_irq;

    fault_d = fault_q
            | (!in_ram(i_address) && !in_periph(i_address))
            | (read && !in_ram(read_address) && !in_periph(read_address))
            | ((|write) && !in_ram(write_address) && !in_periph(write_address));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction_q <= '0;
      read_data_q   <= '0;
      irq_q         <= '0;
      fault_q       <= 1'b0;
      swirq_q       <= 1'b0;
    end else begin
      instruction_q <= instruction_d;
      read_data_q   <= read_data_d;
      irq_q         <= irq_d;
      fault_q       <= fault_d;
      swirq_q       <= swirq_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) mem[write_address[AW+1:2]][8*b +: 8] <= write_data[8*b +: 8];
    end
  end

  assign instruction  = instruction_q;
  assign read_data    = read_data_q;
  assign IRQ          = irq_q;
  assign access_fault = fault_q;

endmodule
